// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall sequencer for the 5-stage ARMv8 core.
// It resolves the hazards that forwarding cannot: load-use stalls with a
// programmable bubble count, flushes on taken branches, and freezes the
// pipeline while data memory is not ready.
//
// Parameters:
//   LOAD_USE_CYCLES  bubbles inserted per load-use hazard (legal 1..3)
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   IDEXmemread     EX instruction is a load
//   IDEXrd          EX destination register
//   IFIDrn/IFIDrm   ID source register fields
//   IFIDusesrn/rm   ID instruction actually reads Rn / Rm(Rt)
//   brtaken         branch resolved taken in EX
//   dmem_wait       data memory not ready
//   PCwrite, IFIDwrite, EXMEMwrite, MEMWBwrite   load enables
//   IFIDflush       IF/ID loads a NOP
//   IDEXbubble      ID/EX loads a NOP
//   stall_active    FSM is in LDSTALL
//
// Optional feature (macro HAZARD_PERFCNT_EN):
//   perf_clr        synchronous clear of stallcount
//   stallcount      saturating count of cycles with PCwrite == 0
module hazard_ctrl #(
  parameter int unsigned LOAD_USE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       IDEXmemread,
  input  logic [4:0] IDEXrd,
  input  logic [4:0] IFIDrn,
  input  logic [4:0] IFIDrm,
  input  logic       IFIDusesrn,
  input  logic       IFIDusesrm,
  input  logic       brtaken,
  input  logic       dmem_wait,
`ifdef HAZARD_PERFCNT_EN
  input  logic       perf_clr,
  output logic [15:0] stallcount,
`endif
  output logic       PCwrite,
  output logic       IFIDwrite,
  output logic       IFIDflush,
  output logic       IDEXbubble,
  output logic       EXMEMwrite,
  output logic       MEMWBwrite,
  output logic       stall_active
);

  typedef enum logic {RUN, LDSTALL} state_t;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       luh;

  // X31 reads as XZR, so a load targeting it never creates a dependency.
  assign luh = IDEXmemread && (IDEXrd != 5'd31) &&
               ((IFIDusesrn && (IDEXrd == IFIDrn)) ||
                (IFIDusesrm && (IDEXrd == IFIDrm)));

  assign stall_active = (state == LDSTALL);

  always_comb begin
    PCwrite    = 1'b1;
    IFIDwrite  = 1'b1;
    IFIDflush  = 1'b0;
    IDEXbubble = 1'b0;
    EXMEMwrite = 1'b1;
    MEMWBwrite = 1'b1;
    state_nxt  = state;
    cnt_nxt    = cnt;
    if (reset) begin
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IFIDflush  = 1'b1;
      IDEXbubble = 1'b1;
      EXMEMwrite = 1'b0;
      MEMWBwrite = 1'b0;
    end else if (dmem_wait) begin
      // Freeze everything; state and cnt hold so the stall is merely extended.
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      EXMEMwrite = 1'b0;
      MEMWBwrite = 1'b0;
    end else if (brtaken) begin
      // Flush both younger stages; any load-use stall in flight is moot.
      IFIDflush  = 1'b1;
      IDEXbubble = 1'b1;
      state_nxt  = RUN;
      cnt_nxt    = '0;
    end else if (state == LDSTALL) begin
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IDEXbubble = 1'b1;
      if (cnt == 2'd1) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt - 2'd1;
      end
    end else if (luh) begin
      PCwrite    = 1'b0;
      IFIDwrite  = 1'b0;
      IDEXbubble = 1'b1;
      // The first bubble is issued from RUN; LDSTALL covers the rest.
      if (LOAD_USE_CYCLES > 1) begin
        state_nxt = LDSTALL;
        cnt_nxt   = 2'(LOAD_USE_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERFCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallcount <= '0;
    end else if (perf_clr) begin
      stallcount <= '0;
    end else if (!PCwrite && (stallcount != '1)) begin
      stallcount <= stallcount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  typedef struct packed {
    logic       memrd;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       usrn;
    logic       usrm;
    logic       br;
    logic       dw;
  } stim_t;

  typedef struct {
    int          d;
    int          kind;
    logic [15:0] exp;
    string       nm;
  } chk_t;

  // {PCwrite, IFIDwrite, IFIDflush, IDEXbubble, EXMEMwrite, MEMWBwrite, stall_active}
  localparam logic [6:0] DEF      = 7'b1100110;
  localparam logic [6:0] LUS      = 7'b0001110;
  localparam logic [6:0] LUS_ACT  = 7'b0001111;
  localparam logic [6:0] FLUSH    = 7'b1111110;
  localparam logic [6:0] FLUSH_AC = 7'b1111111;
  localparam logic [6:0] FRZ      = 7'b0000000;
  localparam logic [6:0] FRZ_ACT  = 7'b0000001;
  localparam logic [6:0] RST      = 7'b0011000;

  logic  clk = 1'b0;
  logic  reset;
  logic  perf_clr;
  stim_t s1, s3;
  logic [6:0] o1, o3;
  logic  pc1, ifw1, fl1, bb1, exw1, mw1, sa1;
  logic  pc3, ifw3, fl3, bb3, exw3, mw3, sa3;
  logic [15:0] cnt1, cnt3;

  chk_t q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_USE_CYCLES(1)) u1 (
    .clk(clk), .reset(reset),
    .IDEXmemread(s1.memrd), .IDEXrd(s1.rd), .IFIDrn(s1.rn), .IFIDrm(s1.rm),
    .IFIDusesrn(s1.usrn), .IFIDusesrm(s1.usrm), .brtaken(s1.br), .dmem_wait(s1.dw),
`ifdef HAZARD_PERFCNT_EN
    .perf_clr(perf_clr), .stallcount(cnt1),
`endif
    .PCwrite(pc1), .IFIDwrite(ifw1), .IFIDflush(fl1), .IDEXbubble(bb1),
    .EXMEMwrite(exw1), .MEMWBwrite(mw1), .stall_active(sa1)
  );

  hazard_ctrl #(.LOAD_USE_CYCLES(3)) u3 (
    .clk(clk), .reset(reset),
    .IDEXmemread(s3.memrd), .IDEXrd(s3.rd), .IFIDrn(s3.rn), .IFIDrm(s3.rm),
    .IFIDusesrn(s3.usrn), .IFIDusesrm(s3.usrm), .brtaken(s3.br), .dmem_wait(s3.dw),
`ifdef HAZARD_PERFCNT_EN
    .perf_clr(perf_clr), .stallcount(cnt3),
`endif
    .PCwrite(pc3), .IFIDwrite(ifw3), .IFIDflush(fl3), .IDEXbubble(bb3),
    .EXMEMwrite(exw3), .MEMWBwrite(mw3), .stall_active(sa3)
  );

`ifndef HAZARD_PERFCNT_EN
  assign cnt1 = '0;
  assign cnt3 = '0;
`endif

  assign o1 = {pc1, ifw1, fl1, bb1, exw1, mw1, sa1};
  assign o3 = {pc3, ifw3, fl3, bb3, exw3, mw3, sa3};

  // Monitor: every expectation pushed during a cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      chk_t        c;
      logic [15:0] act;
      c = q.pop_front();
      if (c.kind == 1)
        act = cnt3;
      else
        act = (c.d == 1) ? {9'b0, o1} : {9'b0, o3};
      tests++;
      if (act !== c.exp) begin
        fails++;
        $display("FAIL %s: got %h expected %h", c.nm, act, c.exp);
      end
    end
  end

  task automatic expect_out(input int d, input logic [6:0] e, input string nm);
    chk_t c;
    c.d = d; c.kind = 0; c.exp = {9'b0, e}; c.nm = nm;
    q.push_back(c);
  endtask

  task automatic expect_cnt(input logic [15:0] e, input string nm);
    chk_t c;
    c.d = 3; c.kind = 1; c.exp = e; c.nm = nm;
    q.push_back(c);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs to one DUT (other idles), queue its expected outputs, advance.
  task automatic cyc(input int d, input stim_t s, input logic [6:0] e, input string nm);
    if (d == 1) begin s1 = s; s3 = '0; end
    else        begin s3 = s; s1 = '0; end
    expect_out(d, e, nm);
    next_cycle();
  endtask

  function automatic stim_t mk(input logic memrd, input int rd, input int rn, input int rm,
                               input logic usrn, input logic usrm, input logic br, input logic dw);
    stim_t s;
    s.memrd = memrd; s.rd = 5'(rd); s.rn = 5'(rn); s.rm = 5'(rm);
    s.usrn = usrn; s.usrm = usrm; s.br = br; s.dw = dw;
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t I, H, HB, BR, DW, DWB;
    I   = '0;
    H   = mk(1, 5, 5, 0, 1, 0, 0, 0);
    HB  = mk(1, 5, 5, 0, 1, 0, 1, 0);
    BR  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    DW  = mk(0, 0, 0, 0, 0, 0, 0, 1);
    DWB = mk(0, 0, 0, 0, 0, 0, 1, 1);

    reset = 1'b1; perf_clr = 1'b0; s1 = '0; s3 = '0;
    #2;
    expect_out(1, RST, "d1_reset");
    expect_out(3, RST, "d3_reset");
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // LOAD_USE_CYCLES = 1
    cyc(1, I, DEF, "d1_idle");
    cyc(1, H, LUS, "d1_loaduse");
    cyc(1, I, DEF, "d1_after_lu");
    cyc(1, mk(1, 31, 0, 31, 0, 1, 0, 0), DEF, "d1_xzr");
    cyc(1, mk(1, 5, 5, 0, 0, 0, 0, 0), DEF, "d1_rn_unused");
    cyc(1, mk(1, 7, 0, 7, 0, 1, 0, 0), LUS, "d1_rm_hazard");
    cyc(1, HB, FLUSH, "d1_br_luh");
    cyc(1, I, DEF, "d1_after_br");
    cyc(1, DW, FRZ, "d1_dmem_wait");
    cyc(1, mk(0, 5, 5, 0, 1, 0, 0, 0), DEF, "d1_not_load");

    // LOAD_USE_CYCLES = 3
    cyc(3, H, LUS, "d3_c1");
    cyc(3, I, LUS_ACT, "d3_c2");
    cyc(3, I, LUS_ACT, "d3_c3");
    cyc(3, I, DEF, "d3_c4_run");

    cyc(3, H, LUS, "d3_br_c1");
    cyc(3, BR, FLUSH_AC, "d3_br_mid");
    cyc(3, I, DEF, "d3_br_run");

    cyc(3, H, LUS, "d3_dw_c1");
    for (int i = 0; i < 4; i++) cyc(3, DW, FRZ_ACT, $sformatf("d3_dw_freeze%0d", i));
    cyc(3, H, LUS_ACT, "d3_dw_resume1");
    cyc(3, I, LUS_ACT, "d3_dw_resume2");
    cyc(3, I, DEF, "d3_dw_run");

    cyc(3, H, LUS, "d3_dwbr_c1");
    cyc(3, DWB, FRZ_ACT, "d3_dwbr_freeze");
    cyc(3, BR, FLUSH_AC, "d3_dwbr_flush");
    cyc(3, I, DEF, "d3_dwbr_run");

    cyc(3, H, LUS, "d3_rst_c1");
    reset = 1'b1;
    #1;
    cyc(3, H, RST, "d3_rst_mid");
    reset = 1'b0;
    cyc(3, I, DEF, "d3_rst_run");

`ifdef HAZARD_PERFCNT_EN
    perf_clr = 1'b1;
    cyc(3, I, DEF, "perf_clr_cycle");
    perf_clr = 1'b0;
    expect_cnt(16'd0, "perf_cleared");
    cyc(3, H, LUS, "perf_c1");
    cyc(3, DW, FRZ_ACT, "perf_dw1");
    cyc(3, DW, FRZ_ACT, "perf_dw2");
    cyc(3, I, LUS_ACT, "perf_c2");
    cyc(3, I, LUS_ACT, "perf_c3");
    expect_cnt(16'd5, "perf_count5");
    cyc(3, I, DEF, "perf_run");
    perf_clr = 1'b1;
    next_cycle();
    perf_clr = 1'b0;
    expect_cnt(16'd0, "perf_clr_again");
    s3 = DW;
    for (int i = 0; i < 65540; i++) next_cycle();
    expect_cnt(16'hFFFF, "perf_saturate");
    next_cycle();
    expect_cnt(16'hFFFF, "perf_saturate_hold");
    s3 = '0;
    next_cycle();
`endif

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain: got %0d entries expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage ARMv8 core. It sits beside the forwarding unit and covers the cases forwarding cannot resolve:
- load-use hazards: holds IF/ID and inserts a programmable number of bubbles into ID/EX;
- taken branches: flushes the two younger stages;
- data-memory wait: freezes the whole pipeline.

It drives the write-enable, flush and bubble controls of the PC and all pipeline registers.

## Interface
- LOAD_USE_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1–3.

- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high reset
- IDEXmemread  input  1  instruction in EX is a load (LDUR/LDURB)
- IDEXrd  input  5  destination register of the instruction in EX
- IFIDrn  input  5  Rn field of the instruction in ID
- IFIDrm  input  5  Rm (or Rt for stores/CBZ) field of the instruction in ID
- IFIDusesrn  input  1  ID instruction reads Rn
- IFIDusesrm  input  1  ID instruction reads Rm/Rt
- brtaken  input  1  branch resolved taken in EX this cycle
- dmem_wait  input  1  data memory not ready this cycle
- PCwrite  output  1  PC load enable
- IFIDwrite  output  1  IF/ID register load enable
- IFIDflush  output  1  IF/ID register loads a NOP
- IDEXbubble  output  1  ID/EX register loads a NOP (all control bits 0)
- EXMEMwrite  output  1  EX/MEM register load enable
- MEMWBwrite  output  1  MEM/WB register load enable
- stall_active  output  1  FSM is in the LDSTALL state

## Operation
- State: FSM {RUN, LDSTALL} plus a 2-bit bubble counter `cnt`.
- All control outputs are combinational (Mealy) from state, `cnt` and inputs.
- Hazard term: `luh = IDEXmemread && IDEXrd != 31 && ((IFIDusesrn && IDEXrd == IFIDrn) || (IFIDusesrm && IDEXrd == IFIDrm))`.
- Default outputs in RUN with no event:
  - all write enables = 1;
  - IFIDflush = 0, IDEXbubble = 0.
- Priority, highest first:
  1. reset;
  2. dmem_wait;
  3. brtaken;
  4. LDSTALL state;
  5. luh.
- dmem_wait:
  - all of PCwrite, IFIDwrite, EXMEMwrite and MEMWBwrite are 0;
  - IFIDflush = 0 and IDEXbubble = 0;
  - state and `cnt` hold.
- brtaken (no dmem_wait):
  - PCwrite = 1 (PC takes the target);
  - IFIDflush = 1 and IDEXbubble = 1;
  - next state RUN, `cnt` ← 0;
  - aborts any load-use stall in progress.
- RUN with luh:
  - PCwrite = 0, IFIDwrite = 0, IDEXbubble = 1;
  - if LOAD_USE_CYCLES == 1, stay in RUN;
  - otherwise go to LDSTALL with `cnt` ← LOAD_USE_CYCLES−1.
- LDSTALL:
  - PCwrite = 0, IFIDwrite = 0, IDEXbubble = 1;
  - if `cnt` == 1, go to RUN with `cnt` ← 0;
  - otherwise `cnt` ← `cnt`−1;
  - luh is ignored in this state.
- X31 is never a hazard source (XZR).

## Timing
- Reset:
  - asynchronous; state = RUN, `cnt` = 0 immediately;
  - while reset is high: PCwrite = IFIDwrite = EXMEMwrite = MEMWBwrite = 0, IFIDflush = 1, IDEXbubble = 1, stall_active = 0.
- Latency:
  - hazard outputs assert in the same cycle as the triggering inputs;
  - state updates on the next rising clk.
- A load-use hazard costs exactly LOAD_USE_CYCLES stall cycles, not counting dmem_wait cycles, which extend it.
- The forwarding unit then resolves the load result via the MEM/WB path; this block adds no further delay.
- Simultaneous events:
  - brtaken + luh: flush wins, no stall;
  - dmem_wait + brtaken: freeze wins, and brtaken must be held until dmem_wait falls.
- Reset mid-LDSTALL: return to RUN, remaining bubbles discarded.

## Configuration
- HAZARD_PERFCNT_EN defined adds:
  - input perf_clr (1): synchronous clear;
  - output stallcount (16): counts cycles with PCwrite == 0 while reset is low, saturating at 16'hFFFF;
  - reset value 0; perf_clr takes priority over increment.
- Without the macro, the ports and the counter are absent and the behaviour is otherwise identical.

## Test plan
- Load-use, LOAD_USE_CYCLES = 1: IDEXmemread = 1, IDEXrd = 5, IFIDrn = 5, IFIDusesrn = 1 -> that cycle PCwrite = 0, IFIDwrite = 0, IDEXbubble = 1. Next cycle, with IDEXmemread = 0, all enables = 1.
- LOAD_USE_CYCLES = 3, same hazard -> 3 consecutive stall cycles; stall_active = 1 on cycles 2–3; back in RUN on cycle 4.
- Hazard on XZR (IDEXrd = 31 = IFIDrm, IFIDusesrm = 1), and a match with IFIDusesrn = 0 -> no stall, outputs at defaults.
- brtaken = 1 together with luh, and brtaken on the 2nd cycle of a 3-cycle stall -> IFIDflush = 1, IDEXbubble = 1, PCwrite = 1; FSM in RUN next cycle.
- dmem_wait = 1 for 4 cycles during LDSTALL (`cnt` = 2) -> all four enables = 0 throughout, `cnt` frozen at 2; stall resumes afterwards and finishes 2 cycles later. Reset pulsed mid-stall -> reset values at once, RUN after release.
- HAZARD_PERFCNT_EN: 3-cycle load-use stall plus 2 dmem_wait cycles -> stallcount = 5. perf_clr -> 0. Preloading near saturation holds the count at 16'hFFFF.
